// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and access latencies for load_store_unit
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;
  localparam int LAT_LOAD = 3;
  localparam int LAT_STORE_W = 2;
  localparam int LAT_STORE_SUB = 4;
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return s == 2'b11 ? SZ_WORD : s;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  off,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);
  logic [15:0] h;
  logic [7:0]  b;
  logic [31:0] mask;
  logic [31:0] lane;
  assign h = 16'(rword >> {off, 3'b000});
  assign b = h[7:0];
  assign load_val = size == SZ_BYTE ? {{24{sign_ext & b[7]}}, b} :
                    size == SZ_HALF ? {{16{sign_ext & h[15]}}, h} : rword;
  assign mask = (size == SZ_BYTE ? 32'h0000_00ff : 32'h0000_ffff) << {off, 3'b000};
  assign lane = size == SZ_BYTE ? {4{wdata[7:0]}} : {2{wdata[15:0]}};
  assign merged = size == SZ_BYTE || size == SZ_HALF ? (rword & ~mask) | (lane & mask) : wdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word memory; LSU_MISALIGN_TRAP_EN aborts misaligned accesses instead of aligning them
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);
  localparam int AW = ADDR_BITS + 2;
  state_t state, nxt;
  logic          c_we, c_sext, abort, accept, unused;
  logic [1:0]    c_size, sz;
  logic [AW-1:0] c_addr, a_eff;
  logic [31:0]   c_wdata, load_val, merged;
  assign sz = norm_size(size);
`ifdef LSU_MISALIGN_TRAP_EN
  assign abort = (sz == SZ_HALF && addr[0]) || (sz == SZ_WORD && addr[1:0] != 2'b00);
  assign a_eff = addr[AW-1:0];
`else
  assign abort = 1'b0;
  assign a_eff = {addr[AW-1:2], sz == SZ_WORD ? 2'b00 : sz == SZ_HALF ? {addr[1], 1'b0} : addr[1:0]};
`endif
  assign unused = ^addr[31:AW];
  assign accept = state == IDLE && req;
  assign busy = state != IDLE;
  assign mem_addr = state == IDLE ? '0 : 32'(c_addr[AW-1:2]);
  assign mem_re = state == RD && !rst;
  assign mem_we = state == WR && !rst;
  lsu_lane_align u_align (
    .size     (c_size),
    .sign_ext (c_sext),
    .off      (c_addr[1:0]),
    .rword    (mem_rdata),
    .wdata    (c_wdata),
    .load_val (load_val),
    .merged   (merged)
  );
  always_comb begin
    nxt = state == IDLE ? (req && !abort ? (we && sz == SZ_WORD ? WR : RD) : IDLE) :
          state == RD   ? WAIT :
          state == WAIT ? (c_we ? WR : IDLE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      misaligned <= 1'b0;
      rdata      <= '0;
      mem_wdata  <= '0;
      c_we       <= 1'b0;
      c_size     <= SZ_BYTE;
      c_sext     <= 1'b0;
      c_addr     <= '0;
      c_wdata    <= '0;
    end else begin
      state      <= nxt;
      done       <= (accept && abort) || (state == WAIT && !c_we) || state == WR;
      misaligned <= accept && abort;
      if (accept) begin
        c_we    <= we;
        c_size  <= sz;
        c_sext  <= sign_ext;
        c_addr  <= a_eff;
        c_wdata <= wdata;
      end
      if (accept && we && sz == SZ_WORD) mem_wdata <= wdata;
      if (state == WAIT && c_we) mem_wdata <= merged;
      if (state == WAIT && !c_we) rdata <= load_val;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed accesses checked against a byte-array reference model
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst, req, we, sign_ext, busy, done, misaligned, mem_we, mem_re;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [1024];
  logic [7:0]  rb [4096];
  logic [31:0] exp_rd;
  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v |= 32'(rb[(idx * 4 + i) % 4096]) << (8 * i);
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] ea, input int nb, input logic sx);
    logic [31:0] v = 0;
    for (int i = 0; i < nb; i++) v |= 32'(rb[(ea + i) % 4096]) << (8 * i);
    if (sx && nb < 4 && v[8 * nb - 1]) v |= 32'hffff_ffff << (8 * nb);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] ea, input int nb, input logic [31:0] d);
    for (int i = 0; i < nb; i++) rb[(ea + i) % 4096] = d[8 * i +: 8];
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a, input logic [31:0] wd);
    int nb, n, re_at, we_at, re_cnt, we_cnt, idx;
    logic [31:0] ra, wa, wv, ea;
    logic mis;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    mis = (a % nb) != 0;
    ea = a - (a % nb);
    idx = int'((ea / 4) % 1024);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 1; re_at = 0; we_at = 0; re_cnt = 0; we_cnt = 0; ra = 0; wa = 0; wv = 0;
    while (1) begin
      if (mem_re) begin re_cnt++; re_at = n; ra = mem_addr; end
      if (mem_we) begin we_cnt++; we_at = n; wa = mem_addr; wv = mem_wdata; end
      if (done || n >= 20) break;
      @(posedge clk); #1;
      n++;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      check("trap_lat", 32'(n), 32'd1);
      check("trap_mis", {31'b0, misaligned}, 32'd1);
      check("trap_mem", 32'(re_cnt + we_cnt), 32'd0);
      check("trap_rdata", rdata, exp_rd);
      return;
    end
`endif
    check("misaligned", {31'b0, misaligned}, 32'd0);
    if (!w) begin
      exp_rd = ref_load(ea, nb, sx);
      check("ld_lat", 32'(n), 32'd3);
      check("ld_re_at", 32'(re_at), 32'd1);
      check("ld_addr", ra, 32'(idx));
      check("ld_rdata", rdata, exp_rd);
      check("ld_we", 32'(we_cnt), 32'd0);
    end else begin
      ref_store(ea, nb, wd);
      check("st_lat", 32'(n), nb == 4 ? 32'd2 : 32'd4);
      check("st_re", 32'(re_cnt), nb == 4 ? 32'd0 : 32'd1);
      check("st_we_at", 32'(we_at), nb == 4 ? 32'd1 : 32'd3);
      check("st_addr", wa, 32'(idx));
      check("st_wdata", wv, ref_word(idx));
    end
  endtask

  initial begin
    logic [31:0] w0;
    int n, re_cnt;
    for (int i = 0; i < 1024; i++) begin
      w0 = i == 4 ? 32'h8899_aabb : $urandom;
      mem[i] = w0;
      for (int b = 0; b < 4; b++) rb[i * 4 + b] = w0[8 * b +: 8];
    end
    exp_rd = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0; addr = 0; wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_en", {30'b0, mem_we, mem_re}, 32'd0);
    access(1'b0, 2'd0, 1'b1, 32'h13, 0);
    check("t1_signed", rdata, 32'hffff_ff88);
    access(1'b0, 2'd0, 1'b0, 32'h13, 0);
    check("t1_unsigned", rdata, 32'h0000_0088);
    access(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234);
    check("t2_word4", mem[4], 32'h1234_aabb);
    access(1'b1, 2'd2, 1'b0, 32'h20, 32'hdead_beef);
    access(1'b0, 2'd2, 1'b0, 32'h20, 0);
    check("t3_load", rdata, 32'hdead_beef);
    access(1'b0, 2'd2, 1'b0, 32'h22, 0);
    we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h11; wdata = 32'h55; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("t5_in_wr", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_we_gated", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = 0;
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_outs", {done, misaligned, mem_we, mem_re} | rdata | mem_addr | mem_wdata, 32'd0);
    check("t5_word4", mem[4], ref_word(4));
    @(posedge clk); #1;
    check("t5_no_done", {31'b0, done}, 32'd0);
    we = 1'b0; size = 2'd0; sign_ext = 1'b1; addr = 32'h13; req = 1'b1;
    n = 0; re_cnt = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (mem_re) re_cnt++;
    end
    exp_rd = ref_load(32'h13, 1, 1'b1);
    check("t6_one_access", 32'(re_cnt), 32'd1);
    check("t6_rdata", rdata, exp_rd);
    size = 2'd2; addr = 32'h20;
    @(posedge clk); #1;
    req = 1'b0;
    check("t6_re_next", {31'b0, mem_re}, 32'd1);
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    exp_rd = ref_load(32'h20, 4, 1'b0);
    check("t6_lat2", 32'(n), 32'd2);
    check("t6_rdata2", rdata, exp_rd);
    for (int k = 0; k < 300; k++)
      access(1'($urandom), 2'($urandom), 1'($urandom),
             $urandom_range(0, 1) ? $urandom : $urandom_range(0, 63), $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and the word-addressed data memory. Converts byte-addressed byte/halfword/word load and store requests into word accesses on the memory's synchronous one-cycle-latency read/write port. Sub-word stores use a read-modify-write sequence. Sub-word loads are lane-extracted and then sign- or zero-extended. A busy/done handshake stalls the core for multi-cycle accesses.

## Interface
- ADDR_BITS, 10: memory word-index width (1024 words); byte addresses wrap modulo 4·2^ADDR_BITS.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; byte/half taken from the low bits.
- busy  out  1  combinational, equal to (state != IDLE).
- done  out  1  registered one-cycle completion pulse.
- rdata  out  32  registered load result; holds until the next load completes.
- misaligned  out  1  registered; pulses together with done on an aborted access.
- mem_addr  out  32  word index {zeros, addr[ADDR_BITS+1:2]}.
- mem_wdata  out  32  word to write.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  32  memory read data, valid the cycle after mem_re.

## Operation
- States: IDLE, RD, WAIT, WR.
- Accept (IDLE and req): register we, size, sign_ext, addr, wdata.
- Load: IDLE → RD → WAIT → IDLE.
- Word store: IDLE → WR → IDLE.
- Sub-word store: IDLE → RD → WAIT → WR → IDLE.
- RD: mem_re=1. WR: mem_we=1. mem_addr is driven from the captured address in all non-IDLE states; it is 0 in IDLE.
- Lanes are little-endian:
  - byte k=addr[1:0] occupies bits [8k+7:8k];
  - half h=addr[1] occupies bits [16h+15:16h].
- WAIT, load: extract the lane from mem_rdata, extend it, register it into rdata, set done.
- WAIT, sub-word store: merge the wdata lane into mem_rdata and register the result as mem_wdata. All other bytes are unchanged.
- WR: mem_wdata is wdata (word store) or the merged word. done is set on leaving WR.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0. Handling is defined under Configuration.
- req while busy is ignored. There is no queueing; the core holds its request until done.
- A new req is accepted in the same cycle done is high, because busy=0 there.
- Reset values: state=IDLE; done=0, misaligned=0, rdata=0, mem_wdata=0; mem_we=0, mem_re=0, mem_addr=0.
- Reset mid-operation: mem_we and mem_re are gated with ~rst, so a cycle with rst=1 never writes or reads memory. The access in flight is dropped silently and no done is produced.

## Timing
Cycle 0 is the accept cycle.
- Load: mem_re in cycle 1; mem_rdata sampled in cycle 2; done and rdata valid in cycle 3.
- Word store: mem_we in cycle 1; done in cycle 2.
- Sub-word store: mem_re in cycle 1; merge in cycle 2; mem_we in cycle 3; done in cycle 4.
- Misaligned abort (macro defined): done=misaligned=1 in cycle 1; no memory enable asserted.
- done is high for exactly one cycle per accepted, non-reset access.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - misaligned accesses abort from IDLE straight back to IDLE, pulsing done and misaligned in cycle 1;
  - rdata is unchanged and memory is untouched.
- LSU_MISALIGN_TRAP_EN undefined:
  - misaligned is tied to 0;
  - the low address bits are masked to natural alignment (half: addr[0]=0; word: addr[1:0]=0);
  - the access then proceeds normally.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - latency constants LAT_LOAD=3, LAT_STORE_W=2, LAT_STORE_SUB=4.
- One combinational sub-module, lsu_lane_align, performs lane extraction/extension for loads and lane merging for stores. The FSM and registers stay in load_store_unit.

## Test plan
All scenarios use a memory model with one-cycle read latency, preloaded with word 4 = 0x8899AABB.
1. Signed byte load at 0x13 → mem_re in cycle 1 with mem_addr=4; done in cycle 3 with rdata=0xFFFFFF88. The unsigned repeat gives 0x00000088.
2. Half store of 0x1234 at 0x12 → mem_re in cycle 1; mem_we in cycle 3 with mem_addr=4 and mem_wdata=0x1234AABB; done in cycle 4.
3. Word store of 0xDEADBEEF at 0x20 → mem_we in cycle 1 with mem_addr=8; done in cycle 2. A following word load at 0x20 returns 0xDEADBEEF.
4. Word load at 0x22:
   - macro defined → done=misaligned=1 in cycle 1, with no mem_re or mem_we;
   - macro undefined → reads word 8 and misaligned stays 0.
5. rst=1 during the WR cycle of a byte store → mem_we stays 0, word 4 is unchanged, state is IDLE and done stays 0. After reset, all outputs are 0.
6. req held high throughout a load → exactly one access is performed. A second req presented in the done cycle is accepted, and its mem_re follows in the next cycle.
